tx_66b_block_framer: RTL and testbench
======================================

Name: tx_66b_block_framer

Overview:
Upstream neighbour of the GTX external TX gearbox. It accepts whole 64b/66b blocks (2-bit sync header + 64-bit payload) over a valid/ready handshake. Each block is split into two 32-bit words, the payload is scrambled with the self-synchronous x^58+x^39+1 scrambler, and one word is presented per gearbox data-ready cycle. When upstream has no block ready at a block boundary, the block substitutes an idle control block so the gearbox never starves.

Parameters:
SCRAMBLER_SEED, 58'h3FF_FFFF_FFFF_FFFF, scrambler state after reset.
BYPASS_SCRAMBLER, 0, 1 = payload passed unscrambled (bring-up and debug).
UNDERFLOW_CNT_W, 16, width of the idle-insertion counter.

Ports:
i_usrclk2  in  1  user clock; the single clock of the block.
i_rst_n  in  1  synchronous active-low reset.
i_blk_valid  in  1  upstream block valid.
o_blk_ready  out  1  block accepted on the edge where valid && ready.
i_blk_header  in  2  sync header (2'b01 data, 2'b10 control).
i_blk_data  in  64  block payload; bits [31:0] are sent first.
i_gb_data_rdy  in  1  gearbox consumes o_gb_data/o_gb_header on this edge.
o_gb_header  out  2  header of the current block, held for both words.
o_gb_data  out  32  current scrambled word.
o_idle_inserted  out  1  one-cycle pulse when an idle block is substituted.
o_underflow_cnt  out  UNDERFLOW_CNT_W  saturating count of idle insertions.

Behaviour:
- One clock, i_usrclk2. Reset is synchronous and active-low on i_rst_n; a reset mid-block discards the block, the hold register and the scrambler state on the next edge.
- Reset state:
  - hold register empty; o_blk_ready = 1.
  - cur_blk = IDLE_BLOCK (header 2'b10, payload 64'h0000_0000_0000_001E); half = 0.
  - scrambler state = SCRAMBLER_SEED.
  - o_idle_inserted = 0; o_underflow_cnt = 0.
  - o_gb_header = 2'b10.
- Hold register (one block):
  - o_blk_ready = !hold_valid and is registered, so there is no combinational path from i_gb_data_rdy to o_blk_ready.
  - Capture when i_blk_valid && o_blk_ready.
- Output stage:
  - o_gb_header = cur_blk header. o_gb_data = scramble(half ? cur[63:32] : cur[31:0], scr_state).
  - Both outputs are combinational from registers only; they never depend on i_gb_data_rdy.
- Consume edge (i_gb_data_rdy = 1):
  - Scrambler advances 32 bits.
  - If half = 0, set half = 1.
  - If half = 1, set half = 0 and load the next block.
  - With i_gb_data_rdy = 0, all state holds, including the scrambler.
- Next-block load:
  - If hold_valid, move hold to cur_blk and clear hold. ready rises the following cycle.
  - Otherwise, load IDLE_BLOCK, pulse o_idle_inserted and increment o_underflow_cnt, saturating at all-ones.
- Same-edge capture into an empty hold while a load takes place: the load sees the old (empty) hold, so an idle block is inserted and the captured block waits for the next boundary.
- Scrambler per bit, LSB first: out = d ^ s[38] ^ s[57]; s = {s[56:0], out}. Headers are never scrambled.
- BYPASS_SCRAMBLER = 1: out = d, but the state still advances with out.
- Headers 2'b00/2'b11 are passed through unchanged; no checking is done here.
- Sustained throughput: one block per two consume edges with no idle insertion, provided upstream presents valid within 1 cycle of ready.

Decomposition:
- pcs_64b66b_pkg: SYNC_DATA = 2'b01, SYNC_CTRL = 2'b10, BLK_TYPE_IDLE = 8'h1E, IDLE_BLOCK, SCR_W = 58, typedef blk66_t {header, payload}.
- Sub-module scrambler_58x32: combinational function mapping (state, 32-bit data, bypass) to (out, next_state). It is reused by the RX descrambler model in the bench.

Test Plan:
- Reset, BYPASS = 1, i_gb_data_rdy held high, no input -> o_gb_header = 2'b10; o_gb_data alternates 0x0000001E, 0x00000000; o_idle_inserted pulses every 2nd cycle; o_underflow_cnt = 3 after 6 cycles.
- BYPASS = 1, send block {01, 64'hDEADBEEF_01234567} -> words 0x01234567 then 0xDEADBEEF, header 2'b01 on both.
- Gearbox stall pattern: rdy low 3 cycles every 66 -> the output word is held stable while rdy = 0, and no data is lost or duplicated over 200 streamed blocks.
- BYPASS = 0, seed all-ones, random blocks -> a bench descrambler (scrambler_58x32 model) recovers the exact payload sequence.
- Back-to-back valid with rdy always high -> 100 blocks delivered with o_underflow_cnt unchanged after the first block.
- Assert i_rst_n low for 1 cycle mid-block (half = 1) -> next cycle half = 0, idle block, scrambler = seed, o_blk_ready = 1.

Source files
------------

// File: rtl/pcs_64b66b_pkg.sv
// 64b/66b block constants and the block type shared by the TX framer and its scrambler.
// Idle control block is the only block this path ever fabricates on its own.
package pcs_64b66b_pkg;

   localparam logic [1:0] SYNC_DATA     = 2'b01;
   localparam logic [1:0] SYNC_CTRL     = 2'b10;
   localparam logic [7:0] BLK_TYPE_IDLE = 8'h1E;
   localparam int         SCR_W         = 58;

   typedef struct packed {
      logic [1:0]  header;
      logic [63:0] payload;
   } blk66_t;

   localparam blk66_t IDLE_BLOCK = '{header: SYNC_CTRL, payload: {56'h0, BLK_TYPE_IDLE}};

endpackage

// File: rtl/scrambler_58x32.sv
// Self-synchronous x^58+x^39+1 scrambler, 32 bits per call, LSB first; purely combinational.
// Bypass passes data through but the state still shifts in the emitted bits.
module scrambler_58x32
   import pcs_64b66b_pkg::*;
(
   input  logic [SCR_W-1:0] i_state,
   input  logic [31:0]      i_data,
   input  logic             i_bypass,
   output logic [31:0]      o_data,
   output logic [SCR_W-1:0] o_state
);

   logic [SCR_W-1:0] w_s;
   logic             w_b;

   always_comb begin
      w_s    = i_state;
      w_b    = 1'b0;
      o_data = '0;
      for (int i = 0; i < 32; i++) begin
         w_b       = i_bypass ? i_data[i] : (i_data[i] ^ w_s[38] ^ w_s[57]);
         o_data[i] = w_b;
         w_s       = {w_s[SCR_W-2:0], w_b};
      end
      o_state = w_s;
   end

endmodule

// File: rtl/tx_66b_block_framer.sv
// Splits 66b blocks into two scrambled 32b words for the gearbox; one-block hold register, idle fill on underflow.
// Outputs depend only on registers; o_blk_ready is !hold_valid, so gearbox stalls reach upstream a cycle later.
module tx_66b_block_framer
   import pcs_64b66b_pkg::*;
#(
   parameter logic [SCR_W-1:0] SCRAMBLER_SEED   = 58'h3FF_FFFF_FFFF_FFFF,
   parameter bit               BYPASS_SCRAMBLER = 1'b0,
   parameter int               UNDERFLOW_CNT_W  = 16
) (
   input  logic                       i_usrclk2,
   input  logic                       i_rst_n,
   input  logic                       i_blk_valid,
   output logic                       o_blk_ready,
   input  logic [1:0]                 i_blk_header,
   input  logic [63:0]                i_blk_data,
   input  logic                       i_gb_data_rdy,
   output logic [1:0]                 o_gb_header,
   output logic [31:0]                o_gb_data,
   output logic                       o_idle_inserted,
   output logic [UNDERFLOW_CNT_W-1:0] o_underflow_cnt
);

   blk66_t                     r_cur;
   blk66_t                     r_hold;
   logic                       r_hold_vld;
   logic                       r_half;
   logic                       r_idle;
   logic [SCR_W-1:0]           r_scr;
   logic [UNDERFLOW_CNT_W-1:0] r_cnt;

   logic                       w_accept;
   logic                       w_load;
   logic [31:0]                w_word;
   logic [31:0]                w_scr_dat;
   logic [SCR_W-1:0]           w_scr_nxt;

   assign w_accept = i_blk_valid && !r_hold_vld;
   assign w_load   = i_gb_data_rdy && r_half;
   assign w_word   = r_half ? r_cur.payload[63:32] : r_cur.payload[31:0];

   scrambler_58x32 u_scrambler (
      .i_state  (r_scr),
      .i_data   (w_word),
      .i_bypass (BYPASS_SCRAMBLER),
      .o_data   (w_scr_dat),
      .o_state  (w_scr_nxt)
   );

   always_ff @(posedge i_usrclk2) begin
      if (!i_rst_n) begin
         r_cur      <= IDLE_BLOCK;
         r_hold     <= '0;
         r_hold_vld <= 1'b0;
         r_half     <= 1'b0;
         r_idle     <= 1'b0;
         r_scr      <= SCRAMBLER_SEED;
         r_cnt      <= '0;
      end else begin
         r_idle <= 1'b0;
         if (i_gb_data_rdy) begin
            r_scr  <= w_scr_nxt;
            r_half <= !r_half;
         end
         // The load looks at the hold state before this edge's capture.
         if (w_load) begin
            if (r_hold_vld) begin
               r_cur <= r_hold;
            end else begin
               r_cur  <= IDLE_BLOCK;
               r_idle <= 1'b1;
               if (r_cnt != '1) begin
                  r_cnt <= r_cnt + UNDERFLOW_CNT_W'(1);
               end
            end
         end
         if (w_accept) begin
            r_hold     <= '{header: i_blk_header, payload: i_blk_data};
            r_hold_vld <= 1'b1;
         end else if (w_load) begin
            r_hold_vld <= 1'b0;
         end
      end
   end

   assign o_blk_ready     = !r_hold_vld;
   assign o_gb_header     = r_cur.header;
   assign o_gb_data       = w_scr_dat;
   assign o_idle_inserted = r_idle;
   assign o_underflow_cnt = r_cnt;

endmodule

// File: tb/tb_tx_66b_block_framer.sv
// Bench: a bypass and a scrambling instance share stimulus; directed cycle table, then streamed scoreboards.
module tb_tx_66b_block_framer;

   logic        usrclk2;
   logic        rst_n;
   logic        blk_vld;
   logic [1:0]  blk_hdr;
   logic [63:0] blk_dat;
   logic        gb_rdy;

   logic        byp_rdy,  scr_rdy;
   logic [1:0]  byp_hdr,  scr_hdr;
   logic [31:0] byp_dat,  scr_dat;
   logic        byp_idle, scr_idle;
   logic [15:0] byp_cnt,  scr_cnt;

   logic [57:0] ds;
   int          n_chk;
   int          n_err;

   tx_66b_block_framer #(
      .SCRAMBLER_SEED   (58'h3FF_FFFF_FFFF_FFFF),
      .BYPASS_SCRAMBLER (1'b1),
      .UNDERFLOW_CNT_W  (16)
   ) u_dut_byp (
      .i_usrclk2       (usrclk2),
      .i_rst_n         (rst_n),
      .i_blk_valid     (blk_vld),
      .o_blk_ready     (byp_rdy),
      .i_blk_header    (blk_hdr),
      .i_blk_data      (blk_dat),
      .i_gb_data_rdy   (gb_rdy),
      .o_gb_header     (byp_hdr),
      .o_gb_data       (byp_dat),
      .o_idle_inserted (byp_idle),
      .o_underflow_cnt (byp_cnt)
   );

   tx_66b_block_framer #(
      .SCRAMBLER_SEED   (58'h3FF_FFFF_FFFF_FFFF),
      .BYPASS_SCRAMBLER (1'b0),
      .UNDERFLOW_CNT_W  (16)
   ) u_dut_scr (
      .i_usrclk2       (usrclk2),
      .i_rst_n         (rst_n),
      .i_blk_valid     (blk_vld),
      .o_blk_ready     (scr_rdy),
      .i_blk_header    (blk_hdr),
      .i_blk_data      (blk_dat),
      .i_gb_data_rdy   (gb_rdy),
      .o_gb_header     (scr_hdr),
      .o_gb_data       (scr_dat),
      .o_idle_inserted (scr_idle),
      .o_underflow_cnt (scr_cnt)
   );

   initial usrclk2 = 1'b0;
   always #5 usrclk2 = ~usrclk2;

   task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Receiver-side descrambler: plain = c ^ s[38] ^ s[57], state shifts in the line bit.
   function automatic logic [89:0] descr(input logic [31:0] c, input logic [57:0] s_in);
      logic [57:0] s;
      logic [31:0] p;
      s = s_in;
      p = '0;
      for (int i = 0; i < 32; i++) begin
         p[i] = c[i] ^ s[38] ^ s[57];
         s    = {s[56:0], c[i]};
      end
      return {s, p};
   endfunction

   task automatic step();
      logic [89:0] r;
      if (!rst_n) begin
         ds = 58'h3FF_FFFF_FFFF_FFFF;
      end else if (gb_rdy) begin
         r  = descr(scr_dat, ds);
         ds = r[89:32];
      end
      @(posedge usrclk2);
      #1;
   endtask

   task automatic reset_dut();
      rst_n   = 1'b0;
      blk_vld = 1'b0;
      blk_hdr = 2'b00;
      blk_dat = 64'h0;
      gb_rdy  = 1'b0;
      step();
      step();
   endtask

   typedef struct packed {
      logic [1:0]  hdr;
      logic [31:0] dat;
      logic        idle;
      logic [15:0] cnt;
      logic        rdy;
   } row_t;

   row_t tbl [0:12];

   task automatic run_directed();
      logic [89:0] dr;
      tbl = '{
         '{2'b10, 32'h0000001E, 1'b0, 16'd0, 1'b1},
         '{2'b10, 32'h00000000, 1'b0, 16'd0, 1'b1},
         '{2'b10, 32'h0000001E, 1'b1, 16'd1, 1'b1},
         '{2'b10, 32'h00000000, 1'b0, 16'd1, 1'b1},
         '{2'b10, 32'h0000001E, 1'b1, 16'd2, 1'b1},
         '{2'b10, 32'h00000000, 1'b0, 16'd2, 1'b1},
         '{2'b10, 32'h0000001E, 1'b1, 16'd3, 1'b0},
         '{2'b10, 32'h00000000, 1'b0, 16'd3, 1'b0},
         '{2'b01, 32'h01234567, 1'b0, 16'd3, 1'b1},
         '{2'b01, 32'hDEADBEEF, 1'b0, 16'd3, 1'b0},
         '{2'b10, 32'h0000001E, 1'b0, 16'd0, 1'b1},
         '{2'b10, 32'h00000000, 1'b0, 16'd0, 1'b1},
         '{2'b10, 32'h0000001E, 1'b1, 16'd1, 1'b1}
      };
      reset_dut();
      dr = descr(scr_dat, ds);
      chk("rst_ready", 66'(byp_rdy), 66'h1);
      chk("rst_hdr", 66'(byp_hdr), 66'h2);
      chk("rst_dat", 66'(byp_dat), 66'h1E);
      chk("rst_scr_dat", 66'(dr[31:0]), 66'h1E);
      chk("rst_idle", 66'(byp_idle), 66'h0);
      chk("rst_cnt", 66'(byp_cnt), 66'h0);
      rst_n  = 1'b1;
      gb_rdy = 1'b1;
      for (int c = 0; c < 13; c++) begin
         dr = descr(scr_dat, ds);
         chk($sformatf("dir%0d_hdr", c), 66'(byp_hdr), 66'(tbl[c].hdr));
         chk($sformatf("dir%0d_dat", c), 66'(byp_dat), 66'(tbl[c].dat));
         chk($sformatf("dir%0d_scr_dat", c), 66'(dr[31:0]), 66'(tbl[c].dat));
         chk($sformatf("dir%0d_scr_hdr", c), 66'(scr_hdr), 66'(tbl[c].hdr));
         chk($sformatf("dir%0d_idle", c), 66'(byp_idle), 66'(tbl[c].idle));
         chk($sformatf("dir%0d_cnt", c), 66'(byp_cnt), 66'(tbl[c].cnt));
         chk($sformatf("dir%0d_scr_cnt", c), 66'({scr_idle, scr_cnt}), 66'({tbl[c].idle, tbl[c].cnt}));
         chk($sformatf("dir%0d_ready", c), 66'({byp_rdy, scr_rdy}), 66'({tbl[c].rdy, tbl[c].rdy}));
         blk_vld = (c == 5) || (c == 8);
         blk_hdr = 2'b01;
         blk_dat = (c == 5) ? 64'hDEADBEEF_01234567 : 64'hCAFEF00D_55AA33CC;
         rst_n   = (c != 9);
         step();
      end
      blk_vld = 1'b0;
   endtask

   task automatic run_stream(input string name, input int n, input bit stall, input bit chk_uf);
      logic [65:0] exp_q[$];
      logic [65:0] eb;
      logic [65:0] ob;
      logic [89:0] dr;
      logic [31:0] lo_b, lo_p;
      logic [1:0]  hdr_b, hdr_p;
      logic [33:0] held;
      logic [15:0] uf_first, uf_last;
      bit          ph, held_vld, uf_seen, accepted;
      int          sent, got, limit;
      reset_dut();
      rst_n    = 1'b1;
      sent     = 0;
      got      = 0;
      ph       = 1'b0;
      held_vld = 1'b0;
      held     = '0;
      uf_seen  = 1'b0;
      uf_first = '0;
      uf_last  = '0;
      lo_b     = '0;
      lo_p     = '0;
      hdr_b    = '0;
      hdr_p    = '0;
      limit    = n * 6 + 200;
      for (int cyc = 0; cyc < limit && got < n; cyc++) begin
         if (held_vld) chk({name, "_stall_hold"}, 66'({byp_hdr, byp_dat}), 66'(held));
         if (chk_uf && byp_hdr == 2'b01) begin
            if (!uf_seen) uf_first = byp_cnt;
            uf_seen = 1'b1;
            uf_last = byp_cnt;
         end
         gb_rdy = stall ? ((cyc % 66) < 63) : 1'b1;
         if (!blk_vld && sent < n) begin
            blk_hdr = 2'b01;
            blk_dat = {$urandom(), $urandom()};
            blk_vld = 1'b1;
         end
         if (gb_rdy) begin
            dr = descr(scr_dat, ds);
            if (!ph) begin
               lo_b  = byp_dat;
               lo_p  = dr[31:0];
               hdr_b = byp_hdr;
               hdr_p = scr_hdr;
               ph    = 1'b1;
            end else begin
               ph = 1'b0;
               ob = {hdr_b, byp_dat, lo_b};
               if (ob != {2'b10, 64'h0000_0000_0000_001E}) begin
                  got++;
                  eb = (exp_q.size() > 0) ? exp_q.pop_front() : ~ob;
                  chk({name, "_byp_blk"}, ob, eb);
                  chk({name, "_scr_blk"}, {hdr_p, dr[31:0], lo_p}, eb);
               end
            end
            held_vld = 1'b0;
         end else begin
            held     = {byp_hdr, byp_dat};
            held_vld = 1'b1;
         end
         accepted = blk_vld && byp_rdy;
         if (accepted) begin
            exp_q.push_back({blk_hdr, blk_dat});
            sent++;
         end
         step();
         if (accepted) blk_vld = 1'b0;
      end
      blk_vld = 1'b0;
      chk({name, "_blk_count"}, 66'(got), 66'(n));
      if (chk_uf) chk({name, "_underflow_cnt"}, 66'(uf_last), 66'(uf_first));
   endtask

   initial begin
      n_chk   = 0;
      n_err   = 0;
      ds      = 58'h3FF_FFFF_FFFF_FFFF;
      rst_n   = 1'b0;
      blk_vld = 1'b0;
      blk_hdr = 2'b00;
      blk_dat = 64'h0;
      gb_rdy  = 1'b0;
      run_directed();
      run_stream("b2b", 100, 1'b0, 1'b1);
      run_stream("stall", 200, 1'b1, 1'b0);
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1);
   end

endmodule
